// File: rtl/vector_cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vector_cache_pkg                                                           |
// | Shared types for the vector cache read-data path: upstream data payload,   |
// | transaction id and read-data master buffer sizing.                         |
// | Rev 1.0 - initial read-data master buffer types                            |
// +----------------------------------------------------------------------------+
package vector_cache_pkg;

  localparam int MASTER_ID_W = 2;
  localparam int TXN_ID_W    = 6;
  localparam int DATA_W      = 32;

  typedef struct packed {
    logic [MASTER_ID_W-1:0] master_id;
    logic [TXN_ID_W-1:0]    id;
  } txnid_t;

  typedef struct packed {
    txnid_t              txnid;
    logic [DATA_W-1:0]   data;
    logic                last;
  } us_data_pld_t;

  // Default entry count of each per-master read-data buffer
  localparam int RD_DATA_BUF_DEPTH = 4;

  typedef logic [$clog2(RD_DATA_BUF_DEPTH+1)-1:0] rd_buf_cnt_t;

endpackage
`default_nettype wire

// File: rtl/vec_cache_rd_data_buf_mem.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vec_cache_rd_data_buf_mem                                                  |
// | DEPTH x us_data_pld_t register array, one synchronous write port and one   |
// | asynchronous read port. Contents are intentionally not reset.              |
// | Rev 1.0 - initial version                                                  |
// +----------------------------------------------------------------------------+
module vec_cache_rd_data_buf_mem
  import vector_cache_pkg::*;
#(
  parameter int DEPTH  = RD_DATA_BUF_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  us_data_pld_t      wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output us_data_pld_t      rdata_o
);

  us_data_pld_t mem_q [DEPTH];

  // Write the incoming beat into the addressed entry
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule
`default_nettype wire

// File: rtl/vec_cache_rd_data_master_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vec_cache_rd_data_master_buffer                                            |
// | Per-master read-data response FIFO behind the decode crossbar. Absorbs     |
// | routed beats, presents them with valid/ready and returns one credit per    |
// | beat handed to the master. Sticky overflow / misroute error flags.         |
// | Optional feature macro: VEC_CACHE_RD_BUF_BYPASS_EN (0-cycle empty bypass). |
// | Rev 1.0 - initial version                                                  |
// +----------------------------------------------------------------------------+
module vec_cache_rd_data_master_buffer
  import vector_cache_pkg::*;
#(
  parameter int DEPTH     = RD_DATA_BUF_DEPTH,
  parameter int MASTER_ID = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_vld,
  input  us_data_pld_t                 in_pld,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output us_data_pld_t                 out_pld,
  output logic                         credit_rtn,
  output logic [$clog2(DEPTH+1)-1:0]   free_cnt,
  output logic                         err_overflow,
  output logic                         err_misroute
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [PTR_W-1:0]       c_PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]       c_DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [MASTER_ID_W-1:0] c_MASTER_ID = MASTER_ID_W'(MASTER_ID);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             err_overflow_q, err_overflow_d;
  logic             err_misroute_q, err_misroute_d;

  us_data_pld_t     w_mem_rdata;
  logic             w_empty;
  logic             w_full;
  logic             w_bypass;
  logic             w_bypass_take;
  logic             w_pop;
  logic             w_push;
  logic             w_mem_pop;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == c_DEPTH_CNT);

`ifdef VEC_CACHE_RD_BUF_BYPASS_EN
  // Empty buffer: forward the incoming beat straight to the master
  assign w_bypass = w_empty && in_vld;
`else
  assign w_bypass = 1'b0;
`endif

  assign out_vld = !w_empty || w_bypass;
  assign out_pld = w_bypass ? in_pld : (w_empty ? '0 : w_mem_rdata);

  // A bypassed beat taken by the master in the same cycle never touches the FIFO
  assign w_pop         = out_vld && out_rdy;
  assign w_bypass_take = w_bypass && out_rdy;
  assign w_push        = in_vld && (!w_full || w_pop) && !w_bypass_take;
  assign w_mem_pop     = w_pop && !w_bypass_take;

  assign credit_rtn   = w_pop;
  assign free_cnt     = c_DEPTH_CNT - count_q;
  assign err_overflow = err_overflow_q;
  assign err_misroute = err_misroute_q;

  // Next-state for pointers (wrap after DEPTH-1), occupancy and sticky errors
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    err_overflow_d = err_overflow_q;
    err_misroute_d = err_misroute_q;

    if (w_push) begin
      wr_ptr_d = (wr_ptr_q == c_PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    end
    if (w_mem_pop) begin
      rd_ptr_d = (rd_ptr_q == c_PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
    end

    case ({w_push, w_mem_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (in_vld && w_full && !w_pop) begin
      err_overflow_d = 1'b1;
    end
    if (in_vld && (in_pld.txnid.master_id != c_MASTER_ID)) begin
      err_misroute_d = 1'b1;
    end
  end

  // State registers; buffered beats are discarded by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      err_overflow_q <= 1'b0;
      err_misroute_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      err_overflow_q <= err_overflow_d;
      err_misroute_q <= err_misroute_d;
    end
  end

  vec_cache_rd_data_buf_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (PTR_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (w_push),
    .waddr_i (wr_ptr_q),
    .wdata_i (in_pld),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_mem_rdata)
  );

endmodule
`default_nettype wire

// File: tb/tb_vec_cache_rd_data_master_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vec_cache_rd_data_master_buffer                                         |
// | Directed self-checking bench: DEPTH=4 instance (fill, overflow, streaming  |
// | wrap, drain, misroute, latency) and DEPTH=3 instance (credit-driven mixed  |
// | traffic against an in-order scoreboard).                                   |
// | Rev 1.0 - initial version                                                  |
// +----------------------------------------------------------------------------+
module tb_vec_cache_rd_data_master_buffer;
  import vector_cache_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;

  logic         in_vld_a, out_rdy_a, out_vld_a, credit_a, ovf_a, mis_a;
  us_data_pld_t in_pld_a, out_pld_a;
  logic [2:0]   free_a;

  logic         in_vld_b, out_rdy_b, out_vld_b, credit_b, ovf_b, mis_b;
  us_data_pld_t in_pld_b, out_pld_b;
  logic [1:0]   free_b;

  int n_checks = 0;
  int n_fail   = 0;

  vec_cache_rd_data_master_buffer #(.DEPTH(4), .MASTER_ID(0)) u_dut_a (
    .clk (clk), .rst_n (rst_n),
    .in_vld (in_vld_a), .in_pld (in_pld_a),
    .out_vld (out_vld_a), .out_rdy (out_rdy_a), .out_pld (out_pld_a),
    .credit_rtn (credit_a), .free_cnt (free_a),
    .err_overflow (ovf_a), .err_misroute (mis_a)
  );

  vec_cache_rd_data_master_buffer #(.DEPTH(3), .MASTER_ID(2)) u_dut_b (
    .clk (clk), .rst_n (rst_n),
    .in_vld (in_vld_b), .in_pld (in_pld_b),
    .out_vld (out_vld_b), .out_rdy (out_rdy_b), .out_pld (out_pld_b),
    .credit_rtn (credit_b), .free_cnt (free_b),
    .err_overflow (ovf_b), .err_misroute (mis_b)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic us_data_pld_t mk(input int mid, input int id, input int data);
    us_data_pld_t p;
    p.txnid.master_id = MASTER_ID_W'(mid);
    p.txnid.id        = TXN_ID_W'(id);
    p.data            = DATA_W'(data);
    p.last            = 1'b1;
    return p;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    us_data_pld_t q_a[$];
    us_data_pld_t q_b[$];
    us_data_pld_t exp;
    int n_cred, sent, got, credits, cyc;

    rst_n = 1'b0;
    in_vld_a = 1'b0; out_rdy_a = 1'b0; in_pld_a = '0;
    in_vld_b = 1'b0; out_rdy_b = 1'b0; in_pld_b = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_out_vld", out_vld_a, 0);
    check("rst_out_pld", out_pld_a, 0);
    check("rst_credit", credit_a, 0);
    check("rst_free", free_a, 4);
    check("rst_ovf", ovf_a, 0);
    check("rst_mis", mis_a, 0);
    check("rst_free_b", free_b, 3);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill DEPTH=4 with the master stalled
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_vld_a = 1'b1;
      in_pld_a = mk(0, i, 32'hA0 + i);
      q_a.push_back(in_pld_a);
      #1;
      check("fill_free", free_a, 4 - i);
    end
    @(negedge clk);
    in_vld_a = 1'b0;
    #1;
    check("full_free", free_a, 0);
    check("full_vld", out_vld_a, 1);
    check("full_head", out_pld_a, q_a[0]);
    check("full_ovf", ovf_a, 0);
    check("full_mis", mis_a, 0);

    // Fifth beat while full and stalled is dropped
    @(negedge clk);
    in_vld_a = 1'b1;
    in_pld_a = mk(0, 63, 32'hDEAD);
    #1;
    check("ovf_credit", credit_a, 0);
    @(negedge clk);
    in_vld_a = 1'b0;
    #1;
    check("ovf_flag", ovf_a, 1);
    check("ovf_free", free_a, 0);
    check("ovf_head", out_pld_a, q_a[0]);

    // Full buffer streaming: push and pop every cycle across pointer wraps
    n_cred = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_vld_a  = 1'b1;
      out_rdy_a = 1'b1;
      in_pld_a  = mk(0, 4 + i, 32'hB0 + i);
      #1;
      exp = q_a.pop_front();
      check("stream_pld", out_pld_a, exp);
      q_a.push_back(in_pld_a);
      if (credit_a) n_cred++;
    end
    @(negedge clk);
    in_vld_a  = 1'b0;
    out_rdy_a = 1'b0;
    #1;
    check("stream_credits", n_cred, 10);
    check("stream_free", free_a, 0);

    // Drain the remaining four beats in order
    @(negedge clk);
    out_rdy_a = 1'b1;
    for (int k = 0; k < 8 && q_a.size() > 0; k++) begin
      #1;
      check("drain_vld", out_vld_a, 1);
      if (out_vld_a) begin
        exp = q_a.pop_front();
        check("drain_pld", out_pld_a, exp);
      end
      @(negedge clk);
    end
    check("drain_left", q_a.size(), 0);
    out_rdy_a = 1'b0;
    #1;
    check("drain_empty_vld", out_vld_a, 0);
    check("drain_free", free_a, 4);
    check("ovf_sticky", ovf_a, 1);

    // Misrouted beat is flagged yet still delivered
    @(negedge clk);
    in_vld_a = 1'b1;
    in_pld_a = mk(1, 5, 32'hC0);
    exp = in_pld_a;
    @(negedge clk);
    in_vld_a = 1'b0;
    #1;
    check("mis_flag", mis_a, 1);
    check("mis_vld", out_vld_a, 1);
    check("mis_pld", out_pld_a, exp);
    @(negedge clk);
    out_rdy_a = 1'b1;
    #1;
    check("mis_credit", credit_a, 1);
    @(negedge clk);
    out_rdy_a = 1'b0;
    #1;
    check("mis_empty", out_vld_a, 0);
    check("mis_sticky", mis_a, 1);

    // Latency from an empty buffer with the master ready
    @(negedge clk);
    in_vld_a  = 1'b1;
    out_rdy_a = 1'b1;
    in_pld_a  = mk(0, 7, 32'hE0);
    exp = in_pld_a;
    #1;
`ifdef VEC_CACHE_RD_BUF_BYPASS_EN
    check("lat0_vld", out_vld_a, 1);
    check("lat0_credit", credit_a, 1);
    check("lat0_pld", out_pld_a, exp);
`else
    check("lat0_vld", out_vld_a, 0);
    check("lat0_credit", credit_a, 0);
`endif
    @(negedge clk);
    in_vld_a = 1'b0;
    #1;
`ifdef VEC_CACHE_RD_BUF_BYPASS_EN
    check("lat1_vld", out_vld_a, 0);
    check("lat1_credit", credit_a, 0);
`else
    check("lat1_vld", out_vld_a, 1);
    check("lat1_credit", credit_a, 1);
    check("lat1_pld", out_pld_a, exp);
`endif
    @(negedge clk);
    out_rdy_a = 1'b0;
    #1;
    check("lat_free", free_a, 4);
    check("lat_empty", out_vld_a, 0);

    // DEPTH=3: credit-paced sender, random master readiness
    sent = 0; got = 0; credits = 3; n_cred = 0; cyc = 0;
    while (got < 100 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      out_rdy_b = 1'($urandom_range(0, 1));
      if (sent < 100 && credits > 0 && $urandom_range(0, 3) != 0) begin
        in_vld_b = 1'b1;
        in_pld_b = mk(2, sent, 32'h1000 + sent);
        q_b.push_back(in_pld_b);
        sent++;
        credits--;
      end else begin
        in_vld_b = 1'b0;
      end
      #1;
      if (out_vld_b && out_rdy_b) begin
        if (q_b.size() > 0) exp = q_b.pop_front();
        else exp = '1;
        check("rand_pld", out_pld_b, exp);
        got++;
      end
      if (credit_b) begin
        credits++;
        n_cred++;
      end
    end
    @(negedge clk);
    in_vld_b  = 1'b0;
    out_rdy_b = 1'b0;
    #1;
    check("rand_sent", sent, 100);
    check("rand_got", got, 100);
    check("rand_credits", n_cred, 100);
    check("rand_free", free_b, 3);
    check("rand_empty", out_vld_b, 0);
    check("rand_ovf", ovf_b, 0);
    check("rand_mis", mis_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
